// File: rtl/button_event_controller.sv
`default_nettype none
// ============================================================================
// Module   : button_event_controller
// Purpose  : Keypad front end. Synchronises and debounces NUM_BUTTONS raw
//            buttons, decodes a single debounced press into code index+1 and
//            emits it to register REG_ADDR as registered one-cycle write
//            strobes, with optional auto-repeat while the button is held.
// Ports    : clock        - system clock, all logic on posedge
//            resetn       - asynchronous active-low reset
//            buttons      - raw asynchronous button levels, active high
//            ctrlWriteReg - constant register index REG_ADDR[4:0]
//            writeReg     - button code (i+1 for bit i), 0 when idle/invalid
//            wren         - one-cycle registered write strobe
//            state_dbg    - current FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
module button_event_controller #(
  parameter int NUM_BUTTONS     = 9,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REG_ADDR        = 2,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [4:0]             ctrlWriteReg,
  output logic [31:0]            writeReg,
  output logic                   wren,
  output logic [1:0]             state_dbg
);

  localparam int C_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int C_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int C_RPT_W   = $clog2(C_RPT_MAX + 1);

  localparam logic [C_CNT_W-1:0]     C_CNT_LAST    = C_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_CNT_W-1:0]     C_CNT_ONE     = C_CNT_W'(1);
  localparam logic [C_RPT_W-1:0]     C_RPT_DELAY   = C_RPT_W'(REPEAT_DELAY - 1);
  localparam logic [C_RPT_W-1:0]     C_RPT_PERIOD  = C_RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [C_RPT_W-1:0]     C_RPT_ONE     = C_RPT_W'(1);
  localparam logic [NUM_BUTTONS-1:0] C_BTN_ONE     = NUM_BUTTONS'(1);

  localparam logic [1:0] C_ST_IDLE    = 2'd0;
  localparam logic [1:0] C_ST_HELD    = 2'd1;
  localparam logic [1:0] C_ST_LOCKOUT = 2'd2;

  // --------------------------------------------------------------------------
  // Synchroniser and debounce state
  // --------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
  logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
  logic [NUM_BUTTONS-1:0] stable_q, stable_d;
  logic [C_CNT_W-1:0]     cnt_q [NUM_BUTTONS];
  logic [C_CNT_W-1:0]     cnt_d [NUM_BUTTONS];

  always_comb begin
    sync1_d = buttons;
    sync2_d = sync1_q;
  end

  // A bit is accepted only after DEBOUNCE_CYCLES consecutive synchronised
  // samples that differ from the accepted level; any agreeing sample restarts
  // the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == C_CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + C_CNT_ONE;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Decode of the debounced vector
  // --------------------------------------------------------------------------
  logic        w_any;
  logic        w_onehot;
  logic        w_multi;
  logic [31:0] w_code;

  always_comb begin
    w_any    = |stable_q;
    // x & (x-1) clears the lowest set bit; zero result means at most one bit
    w_onehot = w_any && ((stable_q & (stable_q - C_BTN_ONE)) == '0);
    w_multi  = w_any && !w_onehot;
    w_code   = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (stable_q[i]) begin
        w_code = 32'(i + 1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // --------------------------------------------------------------------------
  logic [1:0]         state_q, state_d;
  logic [31:0]        write_q, write_d;
  logic               wren_q, wren_d;
  logic [C_RPT_W-1:0] rpt_q, rpt_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= C_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_ST_IDLE: begin
        if (w_onehot) begin
          state_d = C_ST_HELD;
        end else if (w_multi) begin
          state_d = C_ST_LOCKOUT;
        end
      end
      C_ST_HELD: begin
        if (!w_any) begin
          state_d = C_ST_IDLE;
        end else if (w_multi) begin
          state_d = C_ST_LOCKOUT;
        end
      end
      C_ST_LOCKOUT: begin
        // A leftover single button must be released before new presses count
        if (!w_any) begin
          state_d = C_ST_IDLE;
        end
      end
      default: state_d = C_ST_IDLE;
    endcase
  end

  always_comb begin
    wren_d  = 1'b0;
    write_d = write_q;
    rpt_d   = rpt_q;
    case (state_q)
      C_ST_IDLE: begin
        if (w_onehot) begin
          wren_d  = 1'b1;
          write_d = w_code;
          rpt_d   = C_RPT_DELAY;
        end else begin
          write_d = '0;
        end
      end
      C_ST_HELD: begin
        if (!w_any || w_multi) begin
          write_d = '0;
        end else if (w_code != write_q) begin
          // One button released and another accepted on the same edge
          wren_d  = 1'b1;
          write_d = w_code;
          rpt_d   = C_RPT_DELAY;
        end else if (REPEAT_EN != 0) begin
          if (rpt_q == '0) begin
            wren_d = 1'b1;
            rpt_d  = C_RPT_PERIOD;
          end else begin
            rpt_d = rpt_q - C_RPT_ONE;
          end
        end
      end
      default: begin
        write_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
      write_q  <= '0;
      wren_q   <= 1'b0;
      rpt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      write_q  <= write_d;
      wren_q   <= wren_d;
      rpt_q    <= rpt_d;
    end
  end

  assign ctrlWriteReg = 5'(REG_ADDR);
  assign writeReg     = write_q;
  assign wren         = wren_q;
  assign state_dbg    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_controller
// Purpose  : Self-checking bench for button_event_controller. Three instances:
//            9 buttons without repeat, 9 buttons with repeat (10/4), and
//            16 buttons. Debounce of 4 cycles throughout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [8:0]  btn0, btn1;
  logic [15:0] btn2;
  logic [4:0]  cwr0, cwr1, cwr2;
  logic [31:0] wr0, wr1, wr2;
  logic        wren0, wren1, wren2;
  logic [1:0]  st0, st1, st2;

  int checks   = 0;
  int failures = 0;
  int pulses0  = 0;

  button_event_controller #(
    .NUM_BUTTONS(9), .DEBOUNCE_CYCLES(4), .REG_ADDR(2),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) u_dut0 (
    .clock(clk), .resetn(resetn), .buttons(btn0),
    .ctrlWriteReg(cwr0), .writeReg(wr0), .wren(wren0), .state_dbg(st0)
  );

  button_event_controller #(
    .NUM_BUTTONS(9), .DEBOUNCE_CYCLES(4), .REG_ADDR(2),
    .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) u_dut1 (
    .clock(clk), .resetn(resetn), .buttons(btn1),
    .ctrlWriteReg(cwr1), .writeReg(wr1), .wren(wren1), .state_dbg(st1)
  );

  button_event_controller #(
    .NUM_BUTTONS(16), .DEBOUNCE_CYCLES(4), .REG_ADDR(2),
    .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) u_dut2 (
    .clock(clk), .resetn(resetn), .buttons(btn2),
    .ctrlWriteReg(cwr2), .writeReg(wr2), .wren(wren2), .state_dbg(st2)
  );

  always @(negedge clk) begin
    if (wren0 === 1'b1) pulses0++;
  end

  typedef struct {
    logic [8:0]  btn;
    int          edges;
    logic [31:0] wreg;
    logic        wren;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    logic exp_wren;

    //        btn     edges wreg   wren  state
    vecs[0]  = '{9'h010,  6, 32'd0, 1'b0, 2'd0};  // stable set, FSM not yet
    vecs[1]  = '{9'h010,  1, 32'd5, 1'b1, 2'd1};  // first write, code 5
    vecs[2]  = '{9'h010,  1, 32'd5, 1'b0, 2'd1};
    vecs[3]  = '{9'h010, 50, 32'd5, 1'b0, 2'd1};  // held, no repeat
    vecs[4]  = '{9'h000,  6, 32'd5, 1'b0, 2'd1};  // release not yet seen
    vecs[5]  = '{9'h000,  1, 32'd0, 1'b0, 2'd0};
    vecs[6]  = '{9'h001,  2, 32'd0, 1'b0, 2'd0};  // 2-cycle glitch
    vecs[7]  = '{9'h000, 10, 32'd0, 1'b0, 2'd0};
    vecs[8]  = '{9'h002,  7, 32'd2, 1'b1, 2'd1};  // press button 1
    vecs[9]  = '{9'h082,  6, 32'd2, 1'b0, 2'd1};  // add button 7
    vecs[10] = '{9'h082,  1, 32'd0, 1'b0, 2'd2};  // lockout
    vecs[11] = '{9'h080,  7, 32'd0, 1'b0, 2'd2};  // single leftover, no write
    vecs[12] = '{9'h000,  6, 32'd0, 1'b0, 2'd2};
    vecs[13] = '{9'h000,  1, 32'd0, 1'b0, 2'd0};  // back to idle
    vecs[14] = '{9'h002,  7, 32'd2, 1'b1, 2'd1};
    vecs[15] = '{9'h004,  6, 32'd2, 1'b0, 2'd1};  // swap 1 -> 2 same edge
    vecs[16] = '{9'h004,  1, 32'd3, 1'b1, 2'd1};
    vecs[17] = '{9'h000,  7, 32'd0, 1'b0, 2'd0};

    resetn = 1'b0;
    btn0   = '0;
    btn1   = '0;
    btn2   = '0;
    step(3);
    chk("rst_cwr0", 32'(cwr0), 32'd2);
    chk("rst_cwr1", 32'(cwr1), 32'd2);
    chk("rst_cwr2", 32'(cwr2), 32'd2);
    chk("rst_wr0", wr0, 32'd0);
    chk("rst_wren0", 32'(wren0), 32'd0);
    chk("rst_st0", 32'(st0), 32'd0);
    resetn = 1'b1;
    step(3);

    // Table-driven sequence on the no-repeat instance
    for (int v = 0; v < 18; v++) begin
      btn0 = vecs[v].btn;
      step(vecs[v].edges);
      chk($sformatf("vec%0d_wreg", v), wr0, vecs[v].wreg);
      chk($sformatf("vec%0d_wren", v), 32'(wren0), 32'(vecs[v].wren));
      chk($sformatf("vec%0d_state", v), 32'(st0), 32'(vecs[v].st));
      chk($sformatf("vec%0d_cwr", v), 32'(cwr0), 32'd2);
    end
    chk("table_pulses", pulses0, 4);

    // Reset while a button is held
    btn0 = 9'h008;
    step(7);
    chk("pre_rst_wr", wr0, 32'd4);
    chk("pre_rst_wren", 32'(wren0), 32'd1);
    step(5);
    resetn = 1'b0;
    #1;
    chk("async_rst_wr", wr0, 32'd0);
    chk("async_rst_wren", 32'(wren0), 32'd0);
    chk("async_rst_st", 32'(st0), 32'd0);
    chk("async_rst_cwr", 32'(cwr0), 32'd2);
    step(3);
    resetn = 1'b1;
    p = pulses0;
    step(6);
    chk("post_rst_wr_early", wr0, 32'd0);
    chk("post_rst_wren_early", 32'(wren0), 32'd0);
    step(1);
    chk("post_rst_wr", wr0, 32'd4);
    chk("post_rst_wren", 32'(wren0), 32'd1);
    chk("post_rst_st", 32'(st0), 32'd1);
    step(20);
    chk("post_rst_pulses", pulses0 - p, 1);
    btn0 = '0;
    step(8);
    chk("post_rst_idle", 32'(st0), 32'd0);

    // Auto-repeat instance: first write at offset 0
    btn1 = 9'h100;
    step(7);
    chk("rep_first_wr", wr1, 32'd9);
    chk("rep_first_wren", 32'(wren1), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      step(1);
      exp_wren = (k >= 10) && (((k - 10) % 4) == 0);
      chk($sformatf("rep_wren_off%0d", k), 32'(wren1), 32'(exp_wren));
      chk($sformatf("rep_wr_off%0d", k), wr1, 32'd9);
    end
    btn1 = '0;
    step(8);
    chk("rep_release_st", 32'(st1), 32'd0);
    chk("rep_release_wr", wr1, 32'd0);

    // 16-button instance, top button
    btn2 = 16'h8000;
    step(7);
    chk("b16_wr", wr2, 32'd16);
    chk("b16_wren", 32'(wren2), 32'd1);
    chk("b16_cwr", 32'(cwr2), 32'd2);
    step(3);
    chk("b16_wr_hold", wr2, 32'd16);
    chk("b16_wren_hold", 32'(wren2), 32'd0);
    chk("b16_cwr_hold", 32'(cwr2), 32'd2);
    btn2 = '0;
    step(8);
    chk("b16_release_st", 32'(st2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/button_event_controller.md
Name: button_event_controller

Overview:
- Parametrised keypad front end for the pet-feeder CPU.
- Synchronises and debounces N raw buttons, then decodes a single valid press into code index+1.
- Writes the code to register file entry REG_ADDR as one-cycle write pulses.
- Supports optional auto-repeat while a button is held. Replaces the fixed 9-button level decoder.

Parameters:
NUM_BUTTONS, 9, number of button inputs (1..31)
DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a change (>=1)
REG_ADDR, 2, register index driven on ctrlWriteReg
REPEAT_EN, 0, 1 = emit repeated writes while held
REPEAT_DELAY, 1000, cycles from first write to first repeat write
REPEAT_PERIOD, 250, cycles between subsequent repeat writes

Ports:
clock  input  1  system clock, all logic on posedge
resetn  input  1  asynchronous active-low reset
buttons  input  NUM_BUTTONS  raw asynchronous button levels, active high, bit i = button i
ctrlWriteReg  output  5  constant REG_ADDR[4:0]
writeReg  output  32  button code: i+1 for bit i; 0 when idle or invalid
wren  output  1  one-cycle write strobe, registered
state_dbg  output  2  current FSM state encoding

Behaviour:
- Reset (resetn low, async):
  - All sync flops, stable vector, counters, writeReg and wren go to 0.
  - FSM goes to IDLE.
  - ctrlWriteReg is always REG_ADDR, including in reset.
- Synchroniser: 2-flop per bit, producing sync[i].
- Debounce, per bit:
  - Counter cnt[i], width clog2(DEBOUNCE_CYCLES+1).
  - If sync[i] == stable[i]: cnt[i] clears to 0.
  - Otherwise cnt[i] increments. When cnt[i] reaches DEBOUNCE_CYCLES-1 while still differing, stable[i] takes sync[i] on that edge and cnt[i] clears.
  - A glitch shorter than DEBOUNCE_CYCLES sync samples never reaches stable.
- Decode:
  - onehot = stable nonzero and exactly one bit set.
  - code = index of that bit + 1.
  - multi = more than one bit set.
- FSM states: IDLE=0, HELD=1, LOCKOUT=2.
  - IDLE:
    - onehot -> HELD, wren=1 and writeReg=code on the same edge. Load repeat counter with REPEAT_DELAY-1.
    - multi -> LOCKOUT.
    - Otherwise stay; writeReg=0.
  - HELD:
    - stable==0 -> IDLE, writeReg=0.
    - multi -> LOCKOUT, writeReg=0, no wren.
    - onehot with code != writeReg (debounced release of one button and press of another on the same edge) -> stay HELD, wren=1, writeReg=new code, repeat counter reloaded with REPEAT_DELAY-1.
    - Same code with REPEAT_EN=1: repeat counter decrements. At 0, wren=1 (writeReg unchanged) and the counter reloads with REPEAT_PERIOD-1.
    - REPEAT_EN=0: no further wren until release.
  - LOCKOUT:
    - wren=0, writeReg=0.
    - Exit to IDLE only when stable==0. A remaining single button does not generate a write.
- wren:
  - Never high for two consecutive cycles when REPEAT_PERIOD>=2.
  - Never high while writeReg==0.
- Latency: a clean press presented before edge 0 gives sync high after edge 1, stable high on edge 1+DEBOUNCE_CYCLES, and wren/writeReg valid after edge 2+DEBOUNCE_CYCLES.
- Repeat counter width: clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). Counter wrap is not permitted; reload is explicit.
- Reset mid-press: everything clears. After resetn rises with a button still held, debounce restarts and one fresh write occurs.
- NUM_BUTTONS=31 drives code 31; the upper bits of writeReg are always 0.

Test Plan:
- Reset, then hold buttons[4] (NUM_BUTTONS=9, DEBOUNCE_CYCLES=4, REPEAT_EN=0) -> single wren pulse, writeReg=5 on edge 6 after press; no further wren for 50 cycles held; writeReg=0 after debounced release.
- Pulse buttons[0] high for 2 cycles only -> stable never set, wren never asserted, writeReg stays 0.
- Press buttons[1], then add buttons[7] -> first write code 2; on the multi-press, LOCKOUT and writeReg=0; release buttons[1] only -> no write; release all -> IDLE, state_dbg=0.
- REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=4, hold buttons[8] for 30 cycles after first write -> wren at offsets 0, 10, 14, 18, 22, 26, 30, writeReg=9 throughout.
- Hold buttons[3], assert resetn low mid-HELD for 3 cycles -> outputs 0 asynchronously; after release of reset, exactly one new write of code 4 after the debounce latency.
- NUM_BUTTONS=16, press buttons[15] -> writeReg=16, ctrlWriteReg=2 throughout.
